// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Every cycle it decides which pipeline registers load, hold or flush.
// It covers load-use bubbles, taken-branch flushes and data-memory wait
// states, and detects a data-memory access that never completes.
// It also keeps a saturating count of the cycles in which the PC was held.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_init,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rt,
    input  logic             ex_memread,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic             exmem_we,
    output logic             memwb_clr,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEMWAIT,
        ST_TIMEOUT
    } state_t;

    // Wait counter value on the last wait cycle allowed before a timeout.
    localparam logic [7:0] LP_WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [7:0]         r_waitCnt;
    logic [7:0]         w_nextWait;
    logic               r_memTimeout;
    logic               w_setTimeout;
    logic [CNT_W-1:0]   r_stallCnt;
    logic               w_ldHz;

    // A load in EX whose destination is read by the instruction in ID.
    // Register 0 is never a real dependency.
    always_comb begin
        w_ldHz = ex_memread && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

    // Next-state logic and Mealy load/hold/flush controls.
    // A memory stall beats a load-use bubble, which in turn suppresses a branch flush.
    // The held branch is presented again and serviced once the pipeline moves.
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        exmem_we     = 1'b1;
        ifid_clr     = 1'b0;
        idex_clr     = 1'b0;
        memwb_clr    = 1'b0;
        w_nextState  = r_state;
        w_nextWait   = r_waitCnt;
        w_setTimeout = 1'b0;

        if (pc_init) begin
            ifid_clr    = 1'b1;
            idex_clr    = 1'b1;
            memwb_clr   = 1'b1;
            w_nextState = ST_RUN;
            w_nextWait  = 8'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_req && !mem_ack) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        exmem_we    = 1'b0;
                        memwb_clr   = 1'b1;
                        w_nextState = ST_MEMWAIT;
                        w_nextWait  = 8'd1;
                    end else if (w_ldHz) begin
                        pc_we    = 1'b0;
                        ifid_we  = 1'b0;
                        idex_clr = 1'b1;
                    end else if (br_taken) begin
                        ifid_clr = 1'b1;
                    end
                end
                ST_MEMWAIT: begin
                    if (!mem_ack) begin
                        pc_we     = 1'b0;
                        ifid_we   = 1'b0;
                        exmem_we  = 1'b0;
                        memwb_clr = 1'b1;
                        if (r_waitCnt == LP_WAIT_LAST) begin
                            w_nextState  = ST_TIMEOUT;
                            w_setTimeout = 1'b1;
                        end else begin
                            w_nextWait = r_waitCnt + 8'd1;
                        end
                    end else begin
                        w_nextState = ST_RUN;
                        w_nextWait  = 8'd0;
                    end
                end
                ST_TIMEOUT: begin
                    pc_we     = 1'b0;
                    ifid_we   = 1'b0;
                    exmem_we  = 1'b0;
                    memwb_clr = 1'b1;
                end
                default: begin
                    w_nextState = ST_RUN;
                    w_nextWait  = 8'd0;
                end
            endcase
        end
    end

    // State, wait counter, sticky timeout flag and saturating stall counter.
    // A restart clears all of them just as reset does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_waitCnt    <= 8'd0;
            r_memTimeout <= 1'b0;
            r_stallCnt   <= '0;
        end else if (pc_init) begin
            r_state      <= ST_RUN;
            r_waitCnt    <= 8'd0;
            r_memTimeout <= 1'b0;
            r_stallCnt   <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWait;
            if (w_setTimeout) begin
                r_memTimeout <= 1'b1;
            end
            if (!pc_we && (r_stallCnt != {CNT_W{1'b1}})) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
        end
    end

    assign mem_timeout = r_memTimeout;
    assign stall_cnt   = r_stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl, built with a 4-bit stall counter
// so that saturation is reachable.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       pc_init;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rt;
    logic       ex_memread;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ack;
    logic       pc_we;
    logic       ifid_we;
    logic       ifid_clr;
    logic       idex_clr;
    logic       exmem_we;
    logic       memwb_clr;
    logic       mem_timeout;
    logic [3:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(
        .MAX_WAIT (8),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_init     (pc_init),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_rt       (ex_rt),
        .ex_memread  (ex_memread),
        .br_taken    (br_taken),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .ifid_clr    (ifid_clr),
        .idex_clr    (idex_clr),
        .exmem_we    (exmem_we),
        .memwb_clr   (memwb_clr),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one input vector and lets the combinational outputs settle.
    task automatic applyStimulus(input logic req, input logic ack,
                                 input logic exMr, input logic [4:0] exRt,
                                 input logic [4:0] idRs, input logic [4:0] idRt,
                                 input logic usesRt, input logic br,
                                 input logic init);
        mem_req    = req;
        mem_ack    = ack;
        ex_memread = exMr;
        ex_rt      = exRt;
        id_rs      = idRs;
        id_rt      = idRt;
        id_uses_rt = usesRt;
        br_taken   = br;
        pc_init    = init;
        #1;
    endtask

    // Compares one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Linear sequence of directed steps; inputs change just after a falling edge.
    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        #2;
        checkOutput("reset_stall_cnt", 32'(stall_cnt), 0);
        checkOutput("reset_timeout", 32'(mem_timeout), 0);
        checkOutput("reset_pc_we", 32'(pc_we), 1);
        checkOutput("reset_memwb_clr", 32'(memwb_clr), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Register 0 is never a load-use dependency.
        applyStimulus(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
        checkOutput("zero_reg_pc_we", 32'(pc_we), 1);
        checkOutput("zero_reg_idex_clr", 32'(idex_clr), 0);
        @(negedge clk);

        // Load-use on rs: exactly one bubble.
        applyStimulus(0, 0, 1, 5'd8, 5'd8, 5'd2, 0, 0, 0);
        checkOutput("lduse_pc_we", 32'(pc_we), 0);
        checkOutput("lduse_ifid_we", 32'(ifid_we), 0);
        checkOutput("lduse_idex_clr", 32'(idex_clr), 1);
        checkOutput("lduse_exmem_we", 32'(exmem_we), 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 5'd8, 5'd8, 5'd2, 0, 0, 0);
        checkOutput("lduse_after_pc_we", 32'(pc_we), 1);
        checkOutput("lduse_after_idex_clr", 32'(idex_clr), 0);
        checkOutput("lduse_stall_cnt", 32'(stall_cnt), 1);
        @(negedge clk);

        // A match on rt only counts when the ID instruction reads rt.
        applyStimulus(0, 0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0);
        checkOutput("rt_unused_pc_we", 32'(pc_we), 1);
        applyStimulus(0, 0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0);
        checkOutput("rt_used_pc_we", 32'(pc_we), 0);
        @(negedge clk);
        checkOutput("rt_stall_cnt", 32'(stall_cnt), 2);

        // Branch together with load-use: bubble first, flush next cycle.
        applyStimulus(0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0);
        checkOutput("brld_idex_clr", 32'(idex_clr), 1);
        checkOutput("brld_ifid_clr", 32'(ifid_clr), 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 5'd8, 5'd8, 5'd0, 0, 1, 0);
        checkOutput("br_ifid_clr", 32'(ifid_clr), 1);
        checkOutput("br_pc_we", 32'(pc_we), 1);
        checkOutput("br_ifid_we", 32'(ifid_we), 1);
        checkOutput("br_idex_clr", 32'(idex_clr), 0);
        @(negedge clk);
        checkOutput("br_stall_cnt", 32'(stall_cnt), 3);

        // Memory wait: three frozen cycles, then the ack cycle advances.
        applyStimulus(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        checkOutput("mw1_pc_we", 32'(pc_we), 0);
        checkOutput("mw1_exmem_we", 32'(exmem_we), 0);
        checkOutput("mw1_memwb_clr", 32'(memwb_clr), 1);
        @(negedge clk);
        checkOutput("mw2_ifid_we", 32'(ifid_we), 0);
        checkOutput("mw2_memwb_clr", 32'(memwb_clr), 1);
        @(negedge clk);
        applyStimulus(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        checkOutput("mw3_br_suppressed", 32'(ifid_clr), 0);
        checkOutput("mw3_pc_we", 32'(pc_we), 0);
        @(negedge clk);
        applyStimulus(1, 1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0);
        checkOutput("ack_pc_we", 32'(pc_we), 1);
        checkOutput("ack_memwb_clr", 32'(memwb_clr), 0);
        checkOutput("ack_idex_clr", 32'(idex_clr), 0);
        checkOutput("ack_ifid_clr", 32'(ifid_clr), 0);
        checkOutput("ack_stall_cnt", 32'(stall_cnt), 6);
        @(negedge clk);
        applyStimulus(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        checkOutput("single_access_pc_we", 32'(pc_we), 1);
        checkOutput("single_access_memwb_clr", 32'(memwb_clr), 0);
        @(negedge clk);
        checkOutput("single_access_stall_cnt", 32'(stall_cnt), 6);

        // Timeout: eight frozen cycles without an ack.
        applyStimulus(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("to_wait_pc_we", 32'(pc_we), 0);
            checkOutput("to_wait_flag", 32'(mem_timeout), 0);
            @(negedge clk);
        end
        checkOutput("to_flag", 32'(mem_timeout), 1);
        checkOutput("to_stall_cnt", 32'(stall_cnt), 14);
        applyStimulus(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        checkOutput("to_frozen_pc_we", 32'(pc_we), 0);
        checkOutput("to_frozen_memwb_clr", 32'(memwb_clr), 1);
        checkOutput("to_frozen_ifid_clr", 32'(ifid_clr), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
        end
        checkOutput("to_sticky_flag", 32'(mem_timeout), 1);
        checkOutput("to_sat_stall_cnt", 32'(stall_cnt), 15);

        // Restart out of the timeout state.
        applyStimulus(1, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1);
        checkOutput("init_pc_we", 32'(pc_we), 1);
        checkOutput("init_ifid_clr", 32'(ifid_clr), 1);
        checkOutput("init_idex_clr", 32'(idex_clr), 1);
        checkOutput("init_memwb_clr", 32'(memwb_clr), 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        checkOutput("init_after_flag", 32'(mem_timeout), 0);
        checkOutput("init_after_stall_cnt", 32'(stall_cnt), 0);
        checkOutput("init_after_pc_we", 32'(pc_we), 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a memory wait.
        applyStimulus(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
        end
        checkOutput("mwrst_before_cnt", 32'(stall_cnt), 3);
        applyStimulus(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        checkOutput("mwrst_ack_pc_we", 32'(pc_we), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mwrst_stall_cnt", 32'(stall_cnt), 0);
        applyStimulus(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        checkOutput("mwrst_run_memwb_clr", 32'(memwb_clr), 1);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mwrst_held_cnt", 32'(stall_cnt), 0);

        // Saturation over twenty stalled cycles, then reset mid-stall.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
        end
        checkOutput("sat_stall_cnt", 32'(stall_cnt), 15);
        checkOutput("sat_flag", 32'(mem_timeout), 1);
        @(negedge clk);
        checkOutput("sat_hold_cnt", 32'(stall_cnt), 15);
        applyStimulus(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        checkOutput("sat_timeout_pc_we", 32'(pc_we), 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("satrst_stall_cnt", 32'(stall_cnt), 0);
        checkOutput("satrst_flag", 32'(mem_timeout), 0);
        checkOutput("satrst_pc_we", 32'(pc_we), 1);
        checkOutput("satrst_memwb_clr", 32'(memwb_clr), 0);
        checkOutput("satrst_exmem_we", 32'(exmem_we), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
